ps2_digit_entry: RTL and testbench
==================================

Name: ps2_digit_entry

Overview:
Parametrised PS/2 keyboard number-entry block, successor to the fixed 3-digit keypad controller. Receives PS/2 device-to-host frames, checks framing and odd parity, and decodes set-2 break codes. Assembles up to NUM_DIGITS decimal digits with backspace, clear and enter editing. Presents the finished number on a valid/ack handshake to the downstream arithmetic/display logic.

Parameters:
NUM_DIGITS, 3, maximum digits held (1..8)
TIMEOUT_CYC, 50000, CLK cycles without a PS2_CLK falling edge before a partial frame is discarded
CNT_W, 4, width of oCount (must hold NUM_DIGITS)

Ports:
CLK  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-low reset
PS2_CLK  input  1  raw PS/2 clock pin (asynchronous)
PS2_DATA  input  1  raw PS/2 data pin (asynchronous)
iAck  input  1  consumer accepts presented number
oDigits  output  4*NUM_DIGITS  BCD digits; bits [3:0] = most recently entered digit
oCount  output  CNT_W  number of digits currently held
oNumValid  output  1  number complete, held until iAck
oLastCode  output  8  last accepted scan code byte
oFrameErr  output  1  one-cycle pulse on a rejected frame
oOverflow  output  1  one-cycle pulse on a digit key pressed while full

Behaviour:
- Reset (reset==0 at a CLK edge): oDigits=0, oCount=0, oNumValid=0, oLastCode=0, oFrameErr=0, oOverflow=0. Receiver goes to IDLE; break/extended flags cleared. Reset mid-frame or while in DONE discards everything.
- Sync: PS2_CLK and PS2_DATA pass through 2-FF synchronisers. A falling edge is prev_sync=1, cur_sync=0. PS2_DATA is sampled in the same cycle the edge is detected.
- Receiver states: IDLE, SHIFT.
  - IDLE: a falling edge with data=0 (start bit) moves to SHIFT with bit counter=1. A falling edge with data=1 is ignored.
  - SHIFT: each falling edge shifts one bit in, LSB first. On the 11th bit the frame is checked: start=0, stop=1, and odd parity over data+parity bits.
  - Pass: the byte is accepted and the receiver returns to IDLE. Fail: oFrameErr pulses for 1 cycle, the byte is dropped, and the receiver returns to IDLE.
  - Watchdog: a counter clears on every falling edge. If it reaches TIMEOUT_CYC while in SHIFT, the receiver returns to IDLE with no error pulse.
- Byte decode: runs the cycle after acceptance. oLastCode updates on every accepted byte.
  - 0xF0 sets the break flag; 0xE0 sets the extended flag.
  - Any other byte is a key code. The action below runs only if the break flag is set; both flags clear after any key code. Make codes produce no action.
  - Extended keys (E0-prefixed) are ignored, except E0 5A (keypad Enter), which is treated as Enter.
- Entry states: ENTRY, DONE. Key actions (break codes only):
  - Digits 0x45,16,1E,26,25,2E,36,3D,3E,46 map to 0..9. In ENTRY with oCount<NUM_DIGITS: oDigits <= {oDigits shifted left 4, digit}, oCount+1. If oCount==NUM_DIGITS: no change, oOverflow pulses.
  - 0x66 (backspace): if oCount>0, oDigits shifts right 4 with a zero fill at the top, oCount-1. At oCount==0 it does nothing.
  - 0x76 (Esc): oDigits=0, oCount=0.
  - 0x5A (Enter): if oCount>0, go to DONE and set oNumValid=1 on the same edge that updates state. At oCount==0 it does nothing.
  - All other codes: no action.
- DONE: all key actions are ignored, but bytes still update oLastCode. oDigits and oCount are held stable.
- Handshake: while oNumValid==1 and iAck==1 at a CLK edge, next cycle oNumValid=0, oDigits=0, oCount=0, state=ENTRY. iAck while oNumValid==0 is ignored. If acceptance and a decoded key fall in the same cycle, the ack wins and the key is dropped.
- Latency: oDigits, oCount and oNumValid update 2 CLK cycles after the cycle in which the stop-bit falling edge is detected.

Test Plan:
- NUM_DIGITS=3. Send 16,F0,16, 1E,F0,1E, 26,F0,26, 5A,F0,5A -> oDigits=12'h123, oCount=3, oNumValid=1 and held. Pulse iAck -> next cycle oNumValid=0, oDigits=0, oCount=0.
- Send digits 1,2,3 then break of 0x25 (4) -> oOverflow pulses for 1 cycle, oDigits stays 12'h123. Send backspace (66,F0,66) -> oDigits=12'h012, oCount=2.
- Send frame 0x16 with a flipped parity bit -> oFrameErr pulses once, oCount unchanged. Send a frame with stop bit=0 -> same response.
- Send 6 bits of a frame, then idle TIMEOUT_CYC+10 cycles, then a clean F0,1E -> no error pulse, oDigits=0x2, oCount=1.
- Enter with oCount=0 -> oNumValid stays 0. Type 7, Enter, then type 9 while in DONE -> oDigits=0x7, oLastCode=0x46.
- Assert reset=0 mid-frame with 2 digits held -> all outputs 0. A following full clean frame decodes normally.

Source files
------------

// File: rtl/ps2_digit_entry.sv
// ps2_digit_entry: PS/2 set-2 receiver with break-code decimal entry, editing and valid/ack hand-off.
module ps2_digit_entry #(
  parameter int NUM_DIGITS  = 3,
  parameter int TIMEOUT_CYC = 50000,
  parameter int CNT_W       = 4
) (
  input  logic                    CLK,
  input  logic                    reset,
  input  logic                    PS2_CLK,
  input  logic                    PS2_DATA,
  input  logic                    iAck,
  output logic [4*NUM_DIGITS-1:0] oDigits,
  output logic [CNT_W-1:0]        oCount,
  output logic                    oNumValid,
  output logic [7:0]              oLastCode,
  output logic                    oFrameErr,
  output logic                    oOverflow
);
  localparam int DW = 4*NUM_DIGITS;
  localparam int WW = $clog2(TIMEOUT_CYC+1);
  typedef enum logic {IDLE, SHIFT} rx_t;
  typedef enum logic {ENTRY, DONE} en_t;
  logic [2:0] ck_q, ck_d;
  logic [1:0] dt_q, dt_d;
  rx_t rx_q, rx_d;
  logic [3:0] bit_q, bit_d;
  logic [9:0] sh_q, sh_d;
  logic [WW-1:0] wd_q, wd_d;
  logic acc_q, acc_d, fe_q, fe_d, brk_q, brk_d, ext_q, ext_d, ov_q, ov_d;
  logic [7:0] byte_q, byte_d, lc_q, lc_d;
  en_t en_q, en_d;
  logic [DW-1:0] dig_q, dig_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic fall, din, ok, key, act, dv;
  logic [3:0] dval;
  logic [10:0] frame;
  always_comb begin
    dv = 1'b1;
    dval = 4'd0;
    case (byte_q)
      8'h45: dval = 4'd0;
      8'h16: dval = 4'd1;
      8'h1E: dval = 4'd2;
      8'h26: dval = 4'd3;
      8'h25: dval = 4'd4;
      8'h2E: dval = 4'd5;
      8'h36: dval = 4'd6;
      8'h3D: dval = 4'd7;
      8'h3E: dval = 4'd8;
      8'h46: dval = 4'd9;
      default: dv = 1'b0;
    endcase
  end
  always_comb begin
    ck_d = {ck_q[1:0], PS2_CLK};
    dt_d = {dt_q[0], PS2_DATA};
    fall = ck_q[2] & ~ck_q[1];
    din = dt_q[1];
    frame = {din, sh_q};
    ok = !frame[0] && frame[10] && ^frame[9:1];
    rx_d = rx_q;
    bit_d = bit_q;
    sh_d = sh_q;
    acc_d = 1'b0;
    fe_d = 1'b0;
    byte_d = byte_q;
    wd_d = fall ? '0 : (wd_q == WW'(TIMEOUT_CYC) ? wd_q : wd_q + 1'b1);
    if (fall) begin
      sh_d = {din, sh_q[9:1]};
      if (rx_q == IDLE) begin
        if (!din) begin
          rx_d = SHIFT;
          bit_d = 4'd1;
        end
      end else if (bit_q == 4'd10) begin
        rx_d = IDLE;
        acc_d = ok;
        fe_d = !ok;
        byte_d = frame[8:1];
      end else bit_d = bit_q + 1'b1;
    end else if (rx_q == SHIFT && wd_q == WW'(TIMEOUT_CYC)) rx_d = IDLE;
    // prefix bytes only arm flags; any other byte is a key code that consumes them
    key = acc_q && byte_q != 8'hF0 && byte_q != 8'hE0;
    act = key && brk_q && (!ext_q || byte_q == 8'h5A);
    brk_d = key ? 1'b0 : brk_q | (acc_q && byte_q == 8'hF0);
    ext_d = key ? 1'b0 : ext_q | (acc_q && byte_q == 8'hE0);
    lc_d = acc_q ? byte_q : lc_q;
    en_d = en_q;
    dig_d = dig_q;
    cnt_d = cnt_q;
    ov_d = 1'b0;
    if (en_q == DONE && iAck) begin
      en_d = ENTRY;
      dig_d = '0;
      cnt_d = '0;
    end else if (act && en_q == ENTRY) begin
      if (dv) begin
        if (cnt_q == CNT_W'(NUM_DIGITS)) ov_d = 1'b1;
        else begin
          dig_d = (dig_q << 4) | DW'(dval);
          cnt_d = cnt_q + 1'b1;
        end
      end else if (byte_q == 8'h66 && cnt_q != '0) begin
        dig_d = dig_q >> 4;
        cnt_d = cnt_q - 1'b1;
      end else if (byte_q == 8'h76) begin
        dig_d = '0;
        cnt_d = '0;
      end else if (byte_q == 8'h5A && cnt_q != '0) en_d = DONE;
    end
  end
  always_ff @(posedge CLK) begin
    if (!reset) begin
      ck_q <= '0;
      dt_q <= '0;
      rx_q <= IDLE;
      bit_q <= '0;
      sh_q <= '0;
      wd_q <= '0;
      acc_q <= 1'b0;
      fe_q <= 1'b0;
      byte_q <= '0;
      brk_q <= 1'b0;
      ext_q <= 1'b0;
      lc_q <= '0;
      en_q <= ENTRY;
      dig_q <= '0;
      cnt_q <= '0;
      ov_q <= 1'b0;
    end else begin
      ck_q <= ck_d;
      dt_q <= dt_d;
      rx_q <= rx_d;
      bit_q <= bit_d;
      sh_q <= sh_d;
      wd_q <= wd_d;
      acc_q <= acc_d;
      fe_q <= fe_d;
      byte_q <= byte_d;
      brk_q <= brk_d;
      ext_q <= ext_d;
      lc_q <= lc_d;
      en_q <= en_d;
      dig_q <= dig_d;
      cnt_q <= cnt_d;
      ov_q <= ov_d;
    end
  end
  assign oDigits = dig_q;
  assign oCount = cnt_q;
  assign oNumValid = en_q == DONE;
  assign oLastCode = lc_q;
  assign oFrameErr = fe_q;
  assign oOverflow = ov_q;
endmodule

// File: tb/tb_ps2_digit_entry.sv
// tb_ps2_digit_entry: directed PS/2 frames with a scoreboard of expected output events.
module tb_ps2_digit_entry;
  localparam int N = 3;
  localparam int TO = 300;
  logic CLK = 1'b0, reset = 1'b0, PS2_CLK = 1'b1, PS2_DATA = 1'b1, iAck = 1'b0;
  logic [11:0] oDigits;
  logic [3:0] oCount;
  logic oNumValid, oFrameErr, oOverflow;
  logic [7:0] oLastCode;
  int checks = 0, errors = 0;
  logic [26:0] expq[$];
  logic [16:0] prev_st = '0;
  logic mon_en = 1'b0;
  always #5 CLK = ~CLK;
  ps2_digit_entry #(.NUM_DIGITS(N), .TIMEOUT_CYC(TO), .CNT_W(4)) dut (
    .CLK(CLK), .reset(reset), .PS2_CLK(PS2_CLK), .PS2_DATA(PS2_DATA), .iAck(iAck),
    .oDigits(oDigits), .oCount(oCount), .oNumValid(oNumValid), .oLastCode(oLastCode),
    .oFrameErr(oFrameErr), .oOverflow(oOverflow)
  );
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask
  task automatic expect_ev(input logic [11:0] d, input logic [3:0] c, input logic nv, input logic fe,
                           input logic ov, input logic [7:0] lc);
    expq.push_back({d, c, nv, fe, ov, lc});
  endtask
  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      PS2_DATA = f[i];
      repeat (5) @(negedge CLK);
      PS2_CLK = 1'b0;
      repeat (5) @(negedge CLK);
      PS2_CLK = 1'b1;
    end
    PS2_DATA = 1'b1;
    repeat (5) @(negedge CLK);
  endtask
  task automatic send(input logic [7:0] b, input logic pflip = 1'b0, input logic stop = 1'b1);
    send_bits({stop, ~^b ^ pflip, b, 1'b0}, 11);
  endtask
  task automatic brk(input logic [7:0] b);
    send(8'hF0);
    send(b);
  endtask
  task automatic ack();
    iAck = 1'b1;
    @(negedge CLK);
    iAck = 1'b0;
    repeat (3) @(negedge CLK);
  endtask
  // any change of digits/count/valid, or any pulse, must match the next queued expectation
  always @(negedge CLK) begin
    logic [26:0] cur, want;
    if (mon_en) begin
      cur = {oDigits, oCount, oNumValid, oFrameErr, oOverflow, oLastCode};
      if ({oDigits, oCount, oNumValid} != prev_st || oFrameErr || oOverflow) begin
        checks++;
        if (expq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event got %h want none", cur);
        end else begin
          want = expq.pop_front();
          if (cur !== want) begin
            errors++;
            $display("FAIL event got %h want %h", cur, want);
          end
        end
      end
      prev_st = {oDigits, oCount, oNumValid};
    end
  end
  initial begin
    repeat (4) @(negedge CLK);
    check("rst_digits", oDigits, 0);
    check("rst_count", oCount, 0);
    check("rst_valid", oNumValid, 0);
    check("rst_last", oLastCode, 0);
    check("rst_fe", oFrameErr, 0);
    check("rst_ov", oOverflow, 0);
    reset = 1'b1;
    mon_en = 1'b1;
    repeat (5) @(negedge CLK);
    send(8'h16);
    expect_ev(12'h001, 1, 0, 0, 0, 8'h16); brk(8'h16);
    send(8'h1E);
    expect_ev(12'h012, 2, 0, 0, 0, 8'h1E); brk(8'h1E);
    send(8'h26);
    expect_ev(12'h123, 3, 0, 0, 0, 8'h26); brk(8'h26);
    send(8'h5A);
    expect_ev(12'h123, 3, 1, 0, 0, 8'h5A); brk(8'h5A);
    repeat (30) @(negedge CLK);
    check("held_valid", oNumValid, 1);
    check("held_digits", oDigits, 12'h123);
    expect_ev(12'h000, 0, 0, 0, 0, 8'h5A); ack();
    check("ack_valid", oNumValid, 0);
    expect_ev(12'h001, 1, 0, 0, 0, 8'h16); brk(8'h16);
    expect_ev(12'h012, 2, 0, 0, 0, 8'h1E); brk(8'h1E);
    expect_ev(12'h123, 3, 0, 0, 0, 8'h26); brk(8'h26);
    expect_ev(12'h123, 3, 0, 0, 1, 8'h25); brk(8'h25);
    send(8'h66);
    expect_ev(12'h012, 2, 0, 0, 0, 8'h66); brk(8'h66);
    expect_ev(12'h012, 2, 0, 1, 0, 8'h66); send(8'h16, 1'b1);
    expect_ev(12'h012, 2, 0, 1, 0, 8'h66); send(8'h16, 1'b0, 1'b0);
    check("ferr_count", oCount, 2);
    expect_ev(12'h000, 0, 0, 0, 0, 8'h76); brk(8'h76);
    send_bits({1'b1, ~^8'h16, 8'h16, 1'b0}, 6);
    repeat (TO + 10) @(negedge CLK);
    expect_ev(12'h002, 1, 0, 0, 0, 8'h1E); brk(8'h1E);
    expect_ev(12'h000, 0, 0, 0, 0, 8'h76); brk(8'h76);
    brk(8'h5A);
    check("enter_empty_valid", oNumValid, 0);
    expect_ev(12'h007, 1, 0, 0, 0, 8'h3D); brk(8'h3D);
    expect_ev(12'h007, 1, 1, 0, 0, 8'h5A); brk(8'h5A);
    brk(8'h46);
    check("done_last", oLastCode, 8'h46);
    check("done_digits", oDigits, 12'h007);
    check("done_count", oCount, 1);
    expect_ev(12'h000, 0, 0, 0, 0, 8'h46); ack();
    expect_ev(12'h001, 1, 0, 0, 0, 8'h16); brk(8'h16);
    send(8'hE0); brk(8'h16);
    send(8'hE0);
    expect_ev(12'h001, 1, 1, 0, 0, 8'h5A); brk(8'h5A);
    expect_ev(12'h000, 0, 0, 0, 0, 8'h5A); ack();
    expect_ev(12'h001, 1, 0, 0, 0, 8'h16); brk(8'h16);
    expect_ev(12'h012, 2, 0, 0, 0, 8'h1E); brk(8'h1E);
    expect_ev(12'h000, 0, 0, 0, 0, 8'h00);
    send_bits({1'b1, ~^8'h26, 8'h26, 1'b0}, 4);
    reset = 1'b0;
    repeat (3) @(negedge CLK);
    check("mid_rst_digits", oDigits, 0);
    check("mid_rst_count", oCount, 0);
    check("mid_rst_last", oLastCode, 0);
    reset = 1'b1;
    repeat (5) @(negedge CLK);
    expect_ev(12'h003, 1, 0, 0, 0, 8'h26); brk(8'h26);
    for (int i = 0; i < 200 && expq.size() != 0; i++) @(negedge CLK);
    check("queue_drained", expq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
